// File: rtl/traffic_signal_timed.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : traffic_signal_timed                                          |
// | Purpose  : Two-way highway/country intersection controller with dwell    |
// |            timers, min/max greens and all-red clearance phases.          |
// | Options  : TRAFFIC_FLASH_EN adds the flash input and flashing state S6.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module traffic_signal_timed #(
    parameter int HWY_MIN_GREEN   = 8,
    parameter int CNTRY_MIN_GREEN = 3,
    parameter int CNTRY_MAX_GREEN = 10,
    parameter int YELLOW_TIME     = 3,
    parameter int ALL_RED_TIME    = 2,
    parameter int CNT_W           = 8
`ifdef TRAFFIC_FLASH_EN
    ,
    parameter int FLASH_HALF      = 4
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
`ifdef TRAFFIC_FLASH_EN
    input  logic             flash,
`endif
    output logic [1:0]       hwy_signal,
    output logic [1:0]       cntry_road_signal,
    output logic [2:0]       state_out,
    output logic [2:0]       next_state_out,
    output logic [CNT_W-1:0] phase_cnt
);

    typedef enum logic [2:0] {
        S_HWY_GREEN    = 3'd0,
        S_HWY_YELLOW   = 3'd1,
        S_ALL_RED_A    = 3'd2,
        S_CNTRY_GREEN  = 3'd3,
        S_CNTRY_YELLOW = 3'd4,
        S_ALL_RED_B    = 3'd5,
        S_FLASH        = 3'd6,
        S_UNUSED       = 3'd7
    } state_t;

    localparam logic [1:0] c_red    = 2'b00;
    localparam logic [1:0] c_yellow = 2'b01;
    localparam logic [1:0] c_green  = 2'b10;

    // Last count value of each phase; the phase ends on the cycle the timer reaches it.
    localparam logic [CNT_W-1:0] c_hwy_min_last   = CNT_W'(HWY_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] c_cntry_min_last = CNT_W'(CNTRY_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] c_cntry_max_last = CNT_W'(CNTRY_MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] c_yellow_last    = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] c_all_red_last   = CNT_W'(ALL_RED_TIME - 1);
`ifdef TRAFFIC_FLASH_EN
    localparam logic [CNT_W-1:0] c_flash_half     = CNT_W'(FLASH_HALF);
    localparam logic [CNT_W-1:0] c_flash_last     = CNT_W'(2 * FLASH_HALF - 1);
`endif

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_hwy;
    logic [1:0]       r_cntry;
    state_t           w_next;
    logic [CNT_W-1:0] w_next_cnt;

    // Lamp decode, applied to the upcoming state so the lamp registers line up with r_state.
    function automatic logic [3:0] f_lamps(input state_t s, input logic [CNT_W-1:0] c);
        logic [3:0] l;
        l = {c_red, c_red};
        case (s)
            S_HWY_GREEN:    l = {c_green,  c_red};
            S_HWY_YELLOW:   l = {c_yellow, c_red};
            S_CNTRY_GREEN:  l = {c_red,    c_green};
            S_CNTRY_YELLOW: l = {c_red,    c_yellow};
`ifdef TRAFFIC_FLASH_EN
            S_FLASH:        l = (c < c_flash_half) ? {c_yellow, c_yellow} : {c_red, c_red};
`endif
            default:        l = {c_red, c_red};
        endcase
        return l;
    endfunction

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_HWY_GREEN:    if (x && (r_cnt >= c_hwy_min_last)) w_next = S_HWY_YELLOW;
            S_HWY_YELLOW:   if (r_cnt == c_yellow_last)         w_next = S_ALL_RED_A;
            S_ALL_RED_A:    if (r_cnt == c_all_red_last)        w_next = S_CNTRY_GREEN;
            S_CNTRY_GREEN:  if ((r_cnt == c_cntry_max_last) ||
                                (!x && (r_cnt >= c_cntry_min_last)))
                                w_next = S_CNTRY_YELLOW;
            S_CNTRY_YELLOW: if (r_cnt == c_yellow_last)         w_next = S_ALL_RED_B;
            S_ALL_RED_B:    if (r_cnt == c_all_red_last)        w_next = S_HWY_GREEN;
`ifdef TRAFFIC_FLASH_EN
            S_FLASH:        w_next = S_ALL_RED_B;
`endif
            default:        w_next = S_HWY_GREEN;
        endcase
`ifdef TRAFFIC_FLASH_EN
        if (flash) w_next = S_FLASH;
`endif
    end

    always_comb begin
        w_next_cnt = r_cnt + CNT_W'(1);
        if (w_next != r_state) begin
            w_next_cnt = '0;
        end else if ((r_state == S_HWY_GREEN) && (r_cnt >= c_hwy_min_last)) begin
            w_next_cnt = c_hwy_min_last;
        end
`ifdef TRAFFIC_FLASH_EN
        else if ((r_state == S_FLASH) && (r_cnt >= c_flash_last)) begin
            w_next_cnt = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_HWY_GREEN;
            r_cnt   <= '0;
            r_hwy   <= c_green;
            r_cntry <= c_red;
        end else begin
            r_state            <= w_next;
            r_cnt              <= w_next_cnt;
            {r_hwy, r_cntry}   <= f_lamps(w_next, w_next_cnt);
        end
    end

    assign state_out         = r_state;
    assign next_state_out    = w_next;
    assign phase_cnt         = r_cnt;
    assign hwy_signal        = r_hwy;
    assign cntry_road_signal = r_cntry;

endmodule
`default_nettype wire

// File: tb/tb_traffic_signal_timed.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_traffic_signal_timed                                       |
// | Purpose  : Randomised and directed bench for traffic_signal_timed with a |
// |            phase/dwell reference model (flash part under TRAFFIC_FLASH_EN)|
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_traffic_signal_timed;

    localparam int HMIN  = 8;
    localparam int CMIN  = 3;
    localparam int CMAX  = 10;
    localparam int YEL   = 3;
    localparam int ALLR  = 2;
    localparam int CW    = 8;
    localparam int FH    = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          x = 1'b0;
    logic          flash = 1'b0;
    logic [1:0]    hwy_signal;
    logic [1:0]    cntry_road_signal;
    logic [2:0]    state_out;
    logic [2:0]    next_state_out;
    logic [CW-1:0] phase_cnt;
    logic [17:0]   obs;

    int total = 0;
    int bad   = 0;
    int ms    = 0;   // model phase
    int mc    = 0;   // model cycles elapsed in phase

    traffic_signal_timed #(
        .HWY_MIN_GREEN   (HMIN),
        .CNTRY_MIN_GREEN (CMIN),
        .CNTRY_MAX_GREEN (CMAX),
        .YELLOW_TIME     (YEL),
        .ALL_RED_TIME    (ALLR),
        .CNT_W           (CW)
`ifdef TRAFFIC_FLASH_EN
        ,
        .FLASH_HALF      (FH)
`endif
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .x                 (x),
`ifdef TRAFFIC_FLASH_EN
        .flash             (flash),
`endif
        .hwy_signal        (hwy_signal),
        .cntry_road_signal (cntry_road_signal),
        .state_out         (state_out),
        .next_state_out    (next_state_out),
        .phase_cnt         (phase_cnt)
    );

    always #5 clk = ~clk;

    assign obs = {state_out, next_state_out, phase_cnt, hwy_signal, cntry_road_signal};

    // Fixed-length phases run in a ring 1->2->3 .. 5->0; greens and flash are request driven.
    function automatic int model_next(input int s, input int c, input logic xv, input logic fv);
        int n;
        case (s)
            0:       n = (xv && (c + 1 >= HMIN)) ? 1 : 0;
            3:       n = ((c + 1 >= CMAX) || (!xv && (c + 1 >= CMIN))) ? 4 : 3;
            6:       n = 5;
            1, 4:    n = (c + 1 >= YEL)  ? (s + 1) : s;
            2, 5:    n = (c + 1 >= ALLR) ? ((s + 1) % 6) : s;
            default: n = 0;
        endcase
`ifdef TRAFFIC_FLASH_EN
        if (fv) n = 6;
`endif
        return n;
    endfunction

    function automatic logic [3:0] model_lamps(input int s, input int c);
        case (s)
            0:       return 4'b10_00;
            1:       return 4'b01_00;
            3:       return 4'b00_10;
            4:       return 4'b00_01;
            6:       return (c < FH) ? 4'b01_01 : 4'b00_00;
            default: return 4'b00_00;
        endcase
    endfunction

    function automatic logic [17:0] model_vec();
        return {3'(ms), 3'(model_next(ms, mc, x, flash)), 8'(mc), model_lamps(ms, mc)};
    endfunction

    task automatic apply(input logic rv, input logic xv);
        reset = rv;
        x     = xv;
        #1;
    endtask

    task automatic clock_it();
        int n;
        n = model_next(ms, mc, x, flash);
        @(posedge clk);
        #1;
        if (!reset) begin
            ms = 0;
            mc = 0;
        end else begin
            if (n != ms)      mc = 0;
            else if (ms == 0) mc = (mc + 1 > HMIN - 1) ? HMIN - 1 : mc + 1;
            else if (ms == 6) mc = (mc + 1) % (2 * FH);
            else              mc = mc + 1;
            ms = n;
        end
    endtask

    task automatic do_reset(input logic xv);
        apply(1'b0, xv);
        clock_it();
    endtask

    task automatic test_reset();
        apply(1'b0, 1'b0);
        clock_it();
        clock_it();
        total++;
        if (obs !== model_vec()) begin
            bad++;
            $display("FAIL reset_state got=%h exp=%h", obs, model_vec());
        end
        for (int i = 0; i < 30; i++) begin
            apply(1'b1, 1'b0);
            total++;
            if (obs !== model_vec()) begin
                bad++;
                $display("FAIL idle_x0 cyc=%0d got=%h exp=%h", i, obs, model_vec());
            end
            clock_it();
        end
        total++;
        if (phase_cnt !== 8'd7 || state_out !== 3'd0) begin
            bad++;
            $display("FAIL idle_saturate got st=%0d cnt=%0d exp st=0 cnt=7", state_out, phase_cnt);
        end
    endtask

    task automatic test_max_green();
        int cnt_per_state [6];
        int exp_dwell [6];
        exp_dwell = '{HMIN, YEL, ALLR, CMAX, YEL, ALLR};
        for (int s = 0; s < 6; s++) cnt_per_state[s] = 0;
        do_reset(1'b1);
        for (int i = 0; i < 28; i++) begin
            apply(1'b1, 1'b1);
            total++;
            if (obs !== model_vec()) begin
                bad++;
                $display("FAIL x_high cyc=%0d got=%h exp=%h", i, obs, model_vec());
            end
            if (state_out < 3'd6) cnt_per_state[state_out]++;
            clock_it();
        end
        for (int s = 0; s < 6; s++) begin
            total++;
            if (cnt_per_state[s] != exp_dwell[s]) begin
                bad++;
                $display("FAIL dwell_s%0d got=%0d exp=%0d", s, cnt_per_state[s], exp_dwell[s]);
            end
        end
        total++;
        if (state_out !== 3'd0 || phase_cnt !== 8'd0) begin
            bad++;
            $display("FAIL cycle_return got st=%0d cnt=%0d exp st=0 cnt=0", state_out, phase_cnt);
        end
    endtask

    task automatic test_min_green();
        bit found = 0;
        int len = 0;
        do_reset(1'b1);
        for (int i = 0; i < 40; i++) begin
            apply(1'b1, 1'b1);
            if (state_out == 3'd3) begin found = 1; break; end
            clock_it();
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL min_green_reach got st=%0d exp st=3 within 40 cycles", state_out);
        end
        for (int i = 0; i < 20 && state_out == 3'd3; i++) begin
            apply(1'b1, (i == 0));
            total++;
            if (obs !== model_vec()) begin
                bad++;
                $display("FAIL min_green cyc=%0d got=%h exp=%h", i, obs, model_vec());
            end
            len++;
            clock_it();
        end
        total++;
        if (len != CMIN || state_out !== 3'd4) begin
            bad++;
            $display("FAIL min_green_len got len=%0d st=%0d exp len=%0d st=4", len, state_out, CMIN);
        end
    endtask

    task automatic test_pulse();
        bit found = 0;
        do_reset(1'b0);
        for (int i = 0; i < 20; i++) begin
            apply(1'b1, 1'b0);
            if (phase_cnt == 8'd7) begin found = 1; break; end
            clock_it();
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL pulse_wait got cnt=%0d exp cnt=7 within 20 cycles", phase_cnt);
        end
        apply(1'b1, 1'b1);
        total++;
        if (next_state_out !== 3'd1 || obs !== model_vec()) begin
            bad++;
            $display("FAIL pulse_next got nxt=%0d obs=%h exp nxt=1 obs=%h", next_state_out, obs, model_vec());
        end
        clock_it();
        apply(1'b1, 1'b0);
        total++;
        if (state_out !== 3'd1 || phase_cnt !== 8'd0 || obs !== model_vec()) begin
            bad++;
            $display("FAIL pulse_taken got obs=%h exp=%h", obs, model_vec());
        end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        do_reset(1'b1);
        for (int i = 0; i < 60; i++) begin
            apply(1'b1, 1'b1);
            if (state_out == 3'd3 && phase_cnt == 8'd4) begin found = 1; break; end
            clock_it();
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL reset_mid_reach got st=%0d cnt=%0d exp st=3 cnt=4", state_out, phase_cnt);
        end
        apply(1'b0, 1'b1);
        clock_it();
        apply(1'b1, 1'b0);
        total++;
        if ({state_out, phase_cnt, hwy_signal, cntry_road_signal} !== {3'd0, 8'd0, 2'b10, 2'b00}) begin
            bad++;
            $display("FAIL reset_mid got st=%0d cnt=%0d hwy=%b cn=%b exp st=0 cnt=0 hwy=10 cn=00",
                     state_out, phase_cnt, hwy_signal, cntry_road_signal);
        end
    endtask

    task automatic test_random();
        int bias = 2;
        do_reset(1'b0);
        for (int i = 0; i < 1500; i++) begin
            if (i % 50 == 0) bias = $urandom_range(0, 4);
`ifdef TRAFFIC_FLASH_EN
            if ($urandom_range(0, 60) == 0) flash = ~flash;
`endif
            apply(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) < bias));
            total++;
            if (obs !== model_vec()) begin
                bad++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, obs, model_vec());
            end
            clock_it();
        end
        flash = 1'b0;
    endtask

`ifdef TRAFFIC_FLASH_EN
    task automatic test_flash();
        bit found = 0;
        do_reset(1'b1);
        for (int i = 0; i < 40; i++) begin
            apply(1'b1, 1'b1);
            if (state_out == 3'd3) begin found = 1; break; end
            clock_it();
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL flash_reach got st=%0d exp st=3", state_out);
        end
        flash = 1'b1;
        apply(1'b1, 1'b1);
        clock_it();
        for (int i = 0; i < 16; i++) begin
            apply(1'b1, 1'b0);
            total++;
            if (state_out !== 3'd6 || {hwy_signal, cntry_road_signal} !== (((i % 8) < FH) ? 4'b0101 : 4'b0000)) begin
                bad++;
                $display("FAIL flash_lamps cyc=%0d got st=%0d lamps=%b", i, state_out, {hwy_signal, cntry_road_signal});
            end
            clock_it();
        end
        flash = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b0);
            total++;
            if (state_out !== ((i < 2) ? 3'd5 : 3'd0) || obs !== model_vec()) begin
                bad++;
                $display("FAIL flash_exit cyc=%0d got=%h exp=%h", i, obs, model_vec());
            end
            clock_it();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_max_green();
        test_min_green();
        test_pulse();
        test_reset_mid();
`ifdef TRAFFIC_FLASH_EN
        test_flash();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
